// File: rtl/alu_issue_ctrl.sv
// Purpose : issue-side controller for the 16-bit ALU. It accepts one op per handshake,
//           validates the opcode and extends the immediate. It then drives registered
//           ALU inputs, waits the op settle time, captures alu_dout and returns the result.
// Latency : legal op result is valid LAT edges after acceptance (LAT = MUL_LAT for MUL, else 1);
//           an illegal op responds with the same 1-edge timing as a single-cycle op.
// Backpr. : op_ready is high only in IDLE, so ops never overlap. The result is held in RESP
//           until res_ready is seen at a clock edge.
// Ports   : clk/rst_n (async active-low); op_* request channel (valid/ready); alu_ctrl/
//           alu_din1/alu_din2 to the ALU, alu_dout back; res_* result channel (valid/ready).
// Config  : define ALU_ISSUE_FLAGS_EN to add res_flags[2:0] = {parity, negative, zero}.
module alu_issue_ctrl #(
  parameter int DATA_W  = 16,
  parameter int IMM_W   = 8,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic              op_imm_sel,
  input  logic [DATA_W-1:0] op_rs,
  input  logic [DATA_W-1:0] op_rt,
  input  logic [IMM_W-1:0]  op_imm,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_din1,
  output logic [DATA_W-1:0] alu_din2,
  input  logic [DATA_W-1:0] alu_dout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic [2:0]        res_flags
`endif
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_illegal;
  logic [3:0]          r_alu_ctrl;
  logic [DATA_W-1:0]   r_alu_din1;
  logic [DATA_W-1:0]   r_alu_din2;
  logic [DATA_W-1:0]   r_res_data;
  logic                r_res_err;

  logic                w_accept;
  logic                w_capture;
  logic                w_legal;
  logic                w_sext;
  logic [CNT_W-1:0]    w_lat_m1;
  logic [DATA_W-1:0]   w_imm_sx;
  logic [DATA_W-1:0]   w_imm_zx;
  logic [DATA_W-1:0]   w_opnd2;
  logic [DATA_W-1:0]   w_cap_data;

  // ---------------------------------------------------------------------------
  // Decode of the request
  // ---------------------------------------------------------------------------
  // 0000, 1110 and 1111 are the only unused encodings.
  assign w_legal  = (op_code != 4'h0) && (op_code < 4'hE);
  // Arithmetic and compare ops (0001..0111) treat the immediate as signed;
  // logic and shift ops take it as an unsigned pattern / shift amount.
  assign w_sext   = (op_code >= 4'h1) && (op_code <= 4'h7);
  assign w_imm_sx = DATA_W'($signed(op_imm));
  assign w_imm_zx = DATA_W'(op_imm);
  assign w_opnd2  = !op_imm_sel ? op_rt : (w_sext ? w_imm_sx : w_imm_zx);
  assign w_lat_m1 = (op_code == 4'h3) ? CNT_W'(MUL_LAT - 1) : '0;

  assign w_accept  = op_valid && op_ready;
  assign w_capture = (r_state == S_EXEC) && (r_cnt == '0);
  // An illegal op never launched anything on the ALU, so its "result" is forced to zero.
  assign w_cap_data = r_illegal ? '0 : alu_dout;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // Illegal ops also pass through EXEC (with a zero count) so every response,
  // legal single-cycle or illegal, becomes valid one edge after acceptance.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_nxt = S_EXEC;
      S_EXEC:  if (r_cnt == '0) w_state_nxt = S_RESP;
      S_RESP:  if (res_ready)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // op_ready is gated by rst_n so no request can appear accepted while reset is held.
  always_comb begin
    op_ready  = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      S_IDLE:  op_ready  = rst_n;
      S_RESP:  res_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Launch registers and settle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_illegal  <= 1'b0;
      r_alu_ctrl <= 4'h0;
      r_alu_din1 <= '0;
      r_alu_din2 <= '0;
    end else if (w_accept) begin
      r_illegal <= !w_legal;
      r_cnt     <= w_legal ? w_lat_m1 : '0;
      // ALU inputs keep their previous values for an illegal op.
      if (w_legal) begin
        r_alu_ctrl <= op_code;
        r_alu_din1 <= op_rs;
        r_alu_din2 <= w_opnd2;
      end
    end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else if (w_capture) begin
      r_res_data <= w_cap_data;
      r_res_err  <= r_illegal;
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  logic [2:0] r_res_flags;

  // Flags are taken from the same value that lands in res_data, so an illegal
  // op reports {parity=0, negative=0, zero=1}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_flags <= 3'b000;
    end else if (w_capture) begin
      r_res_flags <= {^w_cap_data, w_cap_data[DATA_W-1], (w_cap_data == '0)};
    end
  end

  assign res_flags = r_res_flags;
`endif

  assign alu_ctrl = r_alu_ctrl;
  assign alu_din1 = r_alu_din1;
  assign alu_din2 = r_alu_din2;
  assign res_data = r_res_data;
  assign res_err  = r_res_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int DATA_W  = 16;
  localparam int IMM_W   = 8;
  localparam int MUL_LAT = 3;

  logic              clk;
  logic              rst_n;
  logic              op_valid;
  logic              op_ready;
  logic [3:0]        op_code;
  logic              op_imm_sel;
  logic [DATA_W-1:0] op_rs;
  logic [DATA_W-1:0] op_rt;
  logic [IMM_W-1:0]  op_imm;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_din1;
  logic [DATA_W-1:0] alu_din2;
  logic [DATA_W-1:0] alu_dout;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
`ifdef ALU_ISSUE_FLAGS_EN
  logic [2:0]        res_flags;
`endif

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_imm_sel(op_imm_sel),
    .op_rs     (op_rs),
    .op_rt     (op_rt),
    .op_imm    (op_imm),
    .alu_ctrl  (alu_ctrl),
    .alu_din1  (alu_din1),
    .alu_din2  (alu_din2),
    .alu_dout  (alu_dout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    .res_flags (res_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple combinational ALU standing in for the real one.
  always_comb begin
    alu_dout = '0;
    case (alu_ctrl)
      4'h1: alu_dout = alu_din1 + alu_din2;
      4'h2: alu_dout = alu_din1 - alu_din2;
      4'h3: alu_dout = alu_din1 * alu_din2;
      4'h4: alu_dout = {15'd0, $signed(alu_din1) < $signed(alu_din2)};
      4'h5: alu_dout = {15'd0, $signed(alu_din1) > $signed(alu_din2)};
      4'h6: alu_dout = {15'd0, alu_din1 == alu_din2};
      4'h7: alu_dout = {15'd0, alu_din1 != alu_din2};
      4'h8: alu_dout = alu_din1 | alu_din2;
      4'h9: alu_dout = alu_din1 & alu_din2;
      4'hA: alu_dout = alu_din1 ^ alu_din2;
      4'hB: alu_dout = ~alu_din1;
      4'hC: alu_dout = (alu_din2 >= 16) ? '0 : alu_din1 << alu_din2;
      4'hD: alu_dout = (alu_din2 >= 16) ? '0 : alu_din1 >> alu_din2;
      default: alu_dout = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op before edge E0; returns 1 ns after E0 with the request dropped
  // and the op_* fields scrambled to show they are not re-sampled.
  task automatic issue(input logic [3:0] code, input logic sel,
                       input logic [15:0] rs, input logic [15:0] rt, input logic [7:0] imm);
    @(negedge clk);
    op_code    = code;
    op_imm_sel = sel;
    op_rs      = rs;
    op_rt      = rt;
    op_imm     = imm;
    op_valid   = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_rs    = 16'hDEAD;
    op_rt    = 16'hBEEF;
    op_imm   = 8'h5A;
  endtask

  // Take the pending result with a one-edge res_ready pulse.
  task automatic consume(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, "_res_valid_drop"}, res_valid, 0);
    check({tag, "_op_ready_back"}, op_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    op_valid   = 1'b0;
    op_code    = 4'h0;
    op_imm_sel = 1'b0;
    op_rs      = '0;
    op_rt      = '0;
    op_imm     = '0;
    res_ready  = 1'b0;

    // Reset values
    #2;
    check("rst_op_ready", op_ready, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_din1", alu_din1, 0);
    check("rst_din2", alu_din2, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", res_err, 0);
`ifdef ALU_ISSUE_FLAGS_EN
    check("rst_flags", res_flags, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_op_ready", op_ready, 1);

    // 1. add, register operand
    issue(4'h1, 1'b0, 16'h1234, 16'h0101, 8'h00);
    check("add_alu_ctrl", alu_ctrl, 4'h1);
    check("add_din1", alu_din1, 16'h1234);
    check("add_din2", alu_din2, 16'h0101);
    check("add_valid_e0", res_valid, 0);
    check("add_op_ready_busy", op_ready, 0);
    @(posedge clk); #1;
    check("add_valid_e1", res_valid, 1);
    check("add_data", res_data, 16'h1335);
    check("add_err", res_err, 0);
    consume("add");

    // 2. sub with sign-extended immediate, xor with zero-extended immediate
    issue(4'h2, 1'b1, 16'h0005, 16'hAAAA, 8'hFF);
    check("sub_din2_sext", alu_din2, 16'hFFFF);
    @(posedge clk); #1;
    check("sub_data", res_data, 16'h0006);
    consume("sub");
    issue(4'hA, 1'b1, 16'h0005, 16'hAAAA, 8'hFF);
    check("xor_din2_zext", alu_din2, 16'h00FF);
    @(posedge clk); #1;
    check("xor_data", res_data, 16'h00FA);
    consume("xor");

    // Shift amount >= DATA_W passed through unmodified
    issue(4'hD, 1'b1, 16'hFFFF, 16'h0000, 8'h10);
    check("srli_din2", alu_din2, 16'h0010);
    @(posedge clk); #1;
    check("srli_data", res_data, 16'h0000);
    consume("srli");

    // 3. mul with MUL_LAT=3
    issue(4'h3, 1'b0, 16'h0100, 16'h0100, 8'h00);
    check("mul_alu_ctrl", alu_ctrl, 4'h3);
    check("mul_valid_e0", res_valid, 0);
    @(posedge clk); #1;
    check("mul_valid_e1", res_valid, 0);
    @(posedge clk); #1;
    check("mul_valid_e2", res_valid, 0);
    @(posedge clk); #1;
    check("mul_valid_e3", res_valid, 1);
    check("mul_data", res_data, 16'h0000);
    check("mul_err", res_err, 0);
`ifdef ALU_ISSUE_FLAGS_EN
    check("mul_flags", res_flags, 3'b001);
`endif
    consume("mul");

    // 4. illegal opcode
    issue(4'hE, 1'b0, 16'h1111, 16'h2222, 8'h00);
    check("ill_alu_ctrl_kept", alu_ctrl, 4'h3);
    check("ill_din1_kept", alu_din1, 16'h0100);
    check("ill_valid_e0", res_valid, 0);
    @(posedge clk); #1;
    check("ill_valid_e1", res_valid, 1);
    check("ill_err", res_err, 1);
    check("ill_data", res_data, 16'h0000);
`ifdef ALU_ISSUE_FLAGS_EN
    check("ill_flags", res_flags, 3'b001);
`endif
    consume("ill");

    // 5. backpressure: result held, new request refused
    issue(4'h1, 1'b0, 16'h0001, 16'h0002, 8'h00);
    @(posedge clk); #1;
    check("bp_valid", res_valid, 1);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 4'h2;
    op_rs    = 16'h0050;
    op_rt    = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_data", res_data, 16'h0003);
      check("bp_op_ready", op_ready, 0);
      check("bp_alu_ctrl", alu_ctrl, 4'h1);
    end
    op_valid = 1'b0;
    consume("bp");
    check("bp_err_clear", res_err, 0);

    // 6. reset mid-EXEC of a mul
    issue(4'h3, 1'b0, 16'h0003, 16'h0004, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_alu_ctrl", alu_ctrl, 4'h0);
    check("abort_res_valid", res_valid, 0);
    check("abort_op_ready", op_ready, 0);
    check("abort_res_data", res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", res_valid, 0);
    end
    check("abort_op_ready_after", op_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
